// File: rtl/adder_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_nibble_sequencer_pkg;
   localparam int NIBBLE_W    = 4;
   localparam int NIBBLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder; purely combinational, no backpressure.
module ripple_carry_adder_4bit
   import adder_nibble_sequencer_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_a,
   input  logic [NIBBLE_W-1:0] i_b,
   input  logic                i_cin,
   output logic [NIBBLE_W-1:0] o_sum,
   output logic                o_cout
);
   logic [NIBBLE_W:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar k = 0; k < NIBBLE_W; k++) begin : g_fa
      assign o_sum[k]   = i_a[k] ^ i_b[k] ^ w_c[k];
      assign w_c[k+1]   = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
   end

   assign o_cout = w_c[NIBBLE_W];
endmodule

// File: rtl/adder_nibble_sequencer.sv
// Two-requester adder sharing one 4-bit adder, one nibble per cycle; result after NIBBLES+1 cycles.
// Result is held in DONE until rsp_ready; no requests are accepted outside IDLE.
module adder_nibble_sequencer
   import adder_nibble_sequencer_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req0_valid,
   input  logic [NIBBLE_W*NIBBLES-1:0] req0_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] req0_b,
   input  logic                        req0_cin,
   output logic                        req0_ready,
   input  logic                        req1_valid,
   input  logic [NIBBLE_W*NIBBLES-1:0] req1_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] req1_b,
   input  logic                        req1_cin,
   output logic                        req1_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_id,
   output logic [NIBBLE_W*NIBBLES-1:0] rsp_sum,
   output logic                        rsp_cout,
   output logic                        busy
);
   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_carry;
   logic [W-1:0]          r_a;
   logic [W-1:0]          r_b;
   logic [W-1:0]          r_sum;
   logic                  r_cout;
   logic                  r_id;
   logic                  r_last;
   logic                  r_rsp_valid;
   logic                  r_busy;

   logic                  w_idle;
   logic                  w_grant_id;
   logic                  w_hs;
   logic [NIBBLE_W-1:0]   w_nib_a;
   logic [NIBBLE_W-1:0]   w_nib_b;
   logic [NIBBLE_W-1:0]   w_nib_sum;
   logic                  w_nib_cout;

   // On a tie the requester not served last wins; otherwise whoever is valid.
   assign w_idle     = (r_state == ST_IDLE);
   assign w_grant_id = (req0_valid & req1_valid) ? ~r_last : req1_valid;
   assign req0_ready = w_idle & req0_valid & ~w_grant_id;
   assign req1_ready = w_idle & req1_valid &  w_grant_id;
   assign w_hs       = req0_ready | req1_ready;

   assign w_nib_a = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
   assign w_nib_b = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

   ripple_carry_adder_4bit u_rca (
      .i_a    (w_nib_a),
      .i_b    (w_nib_b),
      .i_cin  (r_carry),
      .o_sum  (w_nib_sum),
      .o_cout (w_nib_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_id        <= 1'b0;
         r_last      <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_a     <= w_grant_id ? req1_a : req0_a;
                  r_b     <= w_grant_id ? req1_b : req0_b;
                  r_carry <= w_grant_id ? req1_cin : req0_cin;
                  r_id    <= w_grant_id;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
               r_carry <= w_nib_cout;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == IDX_W'(NIBBLES - 1)) begin
                  r_cout      <= w_nib_cout;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  r_last      <= r_id;
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_id;
   assign rsp_sum   = r_sum;
   assign rsp_cout  = r_cout;
   assign busy      = r_busy;
endmodule
